// File: rtl/stark_fence_ctrl.sv
// stark_fence_ctrl: execution side of FENCE. Tracks outstanding loads and
// stores, waits for the selected classes to drain, optionally flushes the
// store buffer, then pulses done with the fence's ROB tag.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   req_valid/ready     fence issue handshake; req_tag, req_mask latched
//                       req_mask[0]=order loads, [1]=order stores,
//                       [2]=drain store buffer
//   flush               kills an in-progress fence (no done issued)
//   ld_issue/ld_done    load dispatched / completed
//   st_issue/st_done    store dispatched / completed
//   sb_empty, sb_drain  store buffer empty / drain request
//   busy                fence in progress
//   done, done_tag      one-cycle completion pulse and its tag
//   cnt_err             sticky counter under/overflow
//   timeout             one-cycle timeout pulse
//
// Optional feature: define STARK_FENCE_TIMEOUT_EN to bound the wait in
// DRAIN/SBFL to TIMEOUT cycles; otherwise timeout is tied low.
module stark_fence_ctrl #(
    parameter int CNTW    = 6,
    parameter int TAGW    = 6,
    parameter int TIMEOUT = 4096
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [TAGW-1:0] req_tag,
    input  logic [2:0]      req_mask,
    input  logic            flush,
    input  logic            ld_issue,
    input  logic            ld_done,
    input  logic            st_issue,
    input  logic            st_done,
    input  logic            sb_empty,
    output logic            sb_drain,
    output logic            busy,
    output logic            done,
    output logic [TAGW-1:0] done_tag,
    output logic            cnt_err,
    output logic            timeout
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRAIN = 2'd1,
        S_SBFL  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [CNTW-1:0] ld_cnt;
    logic [CNTW-1:0] st_cnt;
    logic [CNTW-1:0] ld_nxt;
    logic [CNTW-1:0] st_nxt;
    logic            ld_bad;
    logic            st_bad;

    logic [TAGW-1:0] tag_q;
    logic [2:0]      mask_q;

    logic drained;
    logic accept;
    logic to_hit;
    logic to_take;

    // Saturating up/down step. MSB of the result flags an attempted
    // under/overflow; the count itself holds in that case.
    function automatic logic [CNTW:0] cnt_step(
        input logic [CNTW-1:0] c,
        input logic            inc,
        input logic            dec
    );
        logic [CNTW:0] r;
        r = {1'b0, c};
        case ({inc, dec})
            2'b10: begin
                if (&c) r[CNTW] = 1'b1;
                else    r[CNTW-1:0] = c + 1'b1;
            end
            2'b01: begin
                if (c == '0) r[CNTW] = 1'b1;
                else         r[CNTW-1:0] = c - 1'b1;
            end
            default: ;
        endcase
        return r;
    endfunction

    assign {ld_bad, ld_nxt} = cnt_step(ld_cnt, ld_issue, ld_done);
    assign {st_bad, st_nxt} = cnt_step(st_cnt, st_issue, st_done);

    // Counters run every cycle, independent of the FSM and of flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            ld_cnt  <= '0;
            st_cnt  <= '0;
            cnt_err <= 1'b0;
        end else begin
            ld_cnt  <= ld_nxt;
            st_cnt  <= st_nxt;
            cnt_err <= cnt_err | ld_bad | st_bad;
        end
    end

    // A request coincident with flush is dropped.
    assign accept = (state == S_IDLE) && req_valid && !flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            tag_q  <= '0;
            mask_q <= '0;
        end else if (accept) begin
            tag_q  <= req_tag;
            mask_q <= req_mask;
        end
    end

    // Evaluated on registered counts, so a completion seen this cycle
    // only releases the fence one cycle later.
    assign drained = (!mask_q[0] || (ld_cnt == '0)) &&
                     (!mask_q[1] || (st_cnt == '0));

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        to_take   = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (flush) begin
                    state_nxt = S_IDLE;
                end else if (drained) begin
                    state_nxt = mask_q[2] ? S_SBFL : S_DONE;
                end else if (to_hit) begin
                    state_nxt = S_DONE;
                    to_take   = 1'b1;
                end
            end
            S_SBFL: begin
                if (flush) begin
                    state_nxt = S_IDLE;
                end else if (sb_empty) begin
                    state_nxt = S_DONE;
                end else if (to_hit) begin
                    state_nxt = S_DONE;
                    to_take   = 1'b1;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        req_ready = 1'b0;
        busy      = 1'b0;
        sb_drain  = 1'b0;
        done      = 1'b0;
        done_tag  = '0;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
            end
            S_DRAIN: begin
                busy = 1'b1;
            end
            S_SBFL: begin
                busy     = 1'b1;
                sb_drain = 1'b1;
            end
            S_DONE: begin
                busy     = 1'b1;
                done     = 1'b1;
                done_tag = tag_q;
            end
            default: ;
        endcase
    end

`ifdef STARK_FENCE_TIMEOUT_EN
    localparam int WCW = $clog2(TIMEOUT) + 1;

    logic [WCW-1:0] wait_cnt;
    logic           to_q;
    logic           waiting;

    assign waiting = (state == S_DRAIN) || (state == S_SBFL);

    // Held at zero outside DRAIN/SBFL, so it starts from zero on entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
            to_q     <= 1'b0;
        end else begin
            to_q <= to_take;
            if (flush || !waiting) wait_cnt <= '0;
            else                   wait_cnt <= wait_cnt + 1'b1;
        end
    end

    assign to_hit  = waiting && (wait_cnt == WCW'(TIMEOUT - 1));
    assign timeout = to_q;
`else
    logic tmo_unused;

    assign to_hit     = 1'b0;
    assign timeout    = 1'b0;
    assign tmo_unused = to_take | (TIMEOUT > 0);
`endif

endmodule

// File: tb/tb_stark_fence_ctrl.sv
// Directed self-checking bench for stark_fence_ctrl.
// Inputs change 1 time unit after the rising edge; outputs are checked there.
module tb_stark_fence_ctrl;

    localparam int CNTW    = 6;
    localparam int TAGW    = 6;
    localparam int TIMEOUT = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            req_valid = 1'b0;
    logic            req_ready;
    logic [TAGW-1:0] req_tag = '0;
    logic [2:0]      req_mask = '0;
    logic            flush = 1'b0;
    logic            ld_issue = 1'b0;
    logic            ld_done = 1'b0;
    logic            st_issue = 1'b0;
    logic            st_done = 1'b0;
    logic            sb_empty = 1'b1;
    logic            sb_drain;
    logic            busy;
    logic            done;
    logic [TAGW-1:0] done_tag;
    logic            cnt_err;
    logic            timeout;

    int n_cmp = 0;
    int n_err = 0;

    stark_fence_ctrl #(
        .CNTW    (CNTW),
        .TAGW    (TAGW),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_tag   (req_tag),
        .req_mask  (req_mask),
        .flush     (flush),
        .ld_issue  (ld_issue),
        .ld_done   (ld_done),
        .st_issue  (st_issue),
        .st_done   (st_done),
        .sb_empty  (sb_empty),
        .sb_drain  (sb_drain),
        .busy      (busy),
        .done      (done),
        .done_tag  (done_tag),
        .cnt_err   (cnt_err),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive a fence for one cycle; the scheduler must only do so when ready.
    task automatic fence(input logic [TAGW-1:0] t, input logic [2:0] m);
        chk("ready_before_req", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_tag   = t;
        req_mask  = m;
        step();
        req_valid = 1'b0;
        req_mask  = '0;
        req_tag   = '0;
    endtask

    initial begin
        // Reset
        rst = 1'b1;
        step(3);
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_tag", {26'd0, done_tag}, 32'd0);
        chk("rst_sbd", {31'd0, sb_drain}, 32'd0);
        chk("rst_err", {31'd0, cnt_err}, 32'd0);
        chk("rst_tmo", {31'd0, timeout}, 32'd0);
        rst = 1'b0;
        step(6);

        // T1: mask=000, done two cycles after acceptance
        fence(6'd5, 3'b000);
        chk("t1_c1_ready", {31'd0, req_ready}, 32'd0);
        chk("t1_c1_busy", {31'd0, busy}, 32'd1);
        chk("t1_c1_done", {31'd0, done}, 32'd0);
        step();
        chk("t1_c2_done", {31'd0, done}, 32'd1);
        chk("t1_c2_tag", {26'd0, done_tag}, 32'd5);
        chk("t1_c2_ready", {31'd0, req_ready}, 32'd0);
        step();
        chk("t1_c3_done", {31'd0, done}, 32'd0);
        chk("t1_c3_ready", {31'd0, req_ready}, 32'd1);
        chk("t1_c3_busy", {31'd0, busy}, 32'd0);

        // T2: three loads outstanding, order loads only
        ld_issue = 1'b1;
        step(3);
        ld_issue = 1'b0;
        fence(6'd9, 3'b001);             // now F+1
        step();                          // F+2
        st_issue = 1'b1;
        step();                          // F+3
        step();                          // F+4
        st_issue = 1'b0;
        ld_done  = 1'b1;
        step();                          // F+5
        ld_done = 1'b0;
        chk("t2_f5_done", {31'd0, done}, 32'd0);
        chk("t2_f5_busy", {31'd0, busy}, 32'd1);
        step();                          // F+6
        ld_done = 1'b1;
        step();                          // F+7
        ld_done = 1'b0;
        step();                          // F+8
        ld_done = 1'b1;
        step();                          // F+9
        ld_done = 1'b0;
        chk("t2_f9_done", {31'd0, done}, 32'd0);
        chk("t2_f9_busy", {31'd0, busy}, 32'd1);
        step();                          // F+10
        chk("t2_f10_done", {31'd0, done}, 32'd1);
        chk("t2_f10_tag", {26'd0, done_tag}, 32'd9);
        step();
        chk("t2_after_done", {31'd0, done}, 32'd0);
        chk("t2_after_ready", {31'd0, req_ready}, 32'd1);

        // Retire the two stores from T2
        st_done = 1'b1;
        step(2);
        st_done = 1'b0;
        chk("t2_err_clean", {31'd0, cnt_err}, 32'd0);

        // T3: order stores + drain store buffer, SB busy 5 cycles
        sb_empty = 1'b0;
        fence(6'd3, 3'b110);             // G+1 in DRAIN
        chk("t3_drain_sbd", {31'd0, sb_drain}, 32'd0);
        chk("t3_drain_busy", {31'd0, busy}, 32'd1);
        step();                          // G+2 SBFL
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("t3_sbd_%0d", i), {31'd0, sb_drain}, 32'd1);
            chk($sformatf("t3_nodone_%0d", i), {31'd0, done}, 32'd0);
            if (i == 4) sb_empty = 1'b1;
            step();
        end
        chk("t3_done", {31'd0, done}, 32'd1);
        chk("t3_tag", {26'd0, done_tag}, 32'd3);
        chk("t3_done_sbd", {31'd0, sb_drain}, 32'd0);
        step();
        chk("t3_idle", {31'd0, req_ready}, 32'd1);

        // T4: flush kills a fence waiting on two loads
        ld_issue = 1'b1;
        step(2);
        ld_issue = 1'b0;
        fence(6'd12, 3'b001);            // H+1 DRAIN
        step();                          // H+2
        flush = 1'b1;
        step();                          // H+3
        flush = 1'b0;
        chk("t4_flush_busy", {31'd0, busy}, 32'd0);
        chk("t4_flush_ready", {31'd0, req_ready}, 32'd1);
        chk("t4_flush_done", {31'd0, done}, 32'd0);
        fence(6'd7, 3'b000);             // H+4
        chk("t4_new_done0", {31'd0, done}, 32'd0);
        step();                          // H+5
        chk("t4_new_done", {31'd0, done}, 32'd1);
        chk("t4_new_tag", {26'd0, done_tag}, 32'd7);
        step();
        chk("t4_post_done", {31'd0, done}, 32'd0);
        // Retire the two loads; a killed fence never reports
        ld_done = 1'b1;
        step(2);
        ld_done = 1'b0;
        chk("t4_no_stale", {31'd0, done}, 32'd0);

        // flush with req_valid in IDLE: request ignored
        flush     = 1'b1;
        req_valid = 1'b1;
        req_tag   = 6'd20;
        step();
        flush     = 1'b0;
        req_valid = 1'b0;
        chk("t4_ign_busy", {31'd0, busy}, 32'd0);
        step();
        chk("t4_ign_done", {31'd0, done}, 32'd0);

        // T5: same-cycle issue+done at zero is neutral
        ld_issue = 1'b1;
        ld_done  = 1'b1;
        step();
        ld_issue = 1'b0;
        ld_done  = 1'b0;
        chk("t5_neutral_err", {31'd0, cnt_err}, 32'd0);
        fence(6'd2, 3'b001);
        step();
        chk("t5_ld_zero_done", {31'd0, done}, 32'd1);
        chk("t5_ld_zero_tag", {26'd0, done_tag}, 32'd2);
        step();
        // done at zero -> sticky error
        ld_done = 1'b1;
        step();
        ld_done = 1'b0;
        chk("t5_under_err", {31'd0, cnt_err}, 32'd1);
        step(4);
        chk("t5_err_sticky", {31'd0, cnt_err}, 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t5_err_rst", {31'd0, cnt_err}, 32'd0);

        // Overflow: 63 stores fit, the 64th sets the error
        st_issue = 1'b1;
        step(63);
        st_issue = 1'b0;
        chk("ovf_63_ok", {31'd0, cnt_err}, 32'd0);
        st_issue = 1'b1;
        step();
        st_issue = 1'b0;
        chk("ovf_64_err", {31'd0, cnt_err}, 32'd1);
        // Reset mid-operation restores everything
        fence(6'd30, 3'b010);
        chk("mid_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_ready", {31'd0, req_ready}, 32'd1);
        chk("mid_rst_err", {31'd0, cnt_err}, 32'd0);
        // Counter restarted at 0: a store fence completes at once
        fence(6'd31, 3'b010);
        step();
        chk("mid_cnt_clr", {31'd0, done}, 32'd1);
        step();

        // T6: stuck store
        st_issue = 1'b1;
        step();
        st_issue = 1'b0;
        fence(6'd17, 3'b010);            // J+1 = first DRAIN cycle
        for (int k = 1; k <= 18; k++) begin
`ifdef STARK_FENCE_TIMEOUT_EN
            chk($sformatf("t6_done_%0d", k), {31'd0, done},
                (k == 17) ? 32'd1 : 32'd0);
            chk($sformatf("t6_tmo_%0d", k), {31'd0, timeout},
                (k == 17) ? 32'd1 : 32'd0);
            if (k == 17)
                chk("t6_tmo_tag", {26'd0, done_tag}, 32'd17);
`else
            chk($sformatf("t6_done_%0d", k), {31'd0, done}, 32'd0);
            chk($sformatf("t6_tmo_%0d", k), {31'd0, timeout}, 32'd0);
`endif
            if (k < 18) step();
        end
`ifndef STARK_FENCE_TIMEOUT_EN
        chk("t6_still_busy", {31'd0, busy}, 32'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
`endif
        chk("t6_end_idle", {31'd0, busy}, 32'd0);
        st_done = 1'b1;
        step();
        st_done = 1'b0;
        chk("t6_final_err", {31'd0, cnt_err}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
